// File: rtl/life_pkg.sv
// Shared types, default rule masks and index helpers for the row-serial Life engine.
package life_pkg;

    localparam logic [8:0] LIFE_B3  = 9'b000001000;
    localparam logic [8:0] LIFE_S23 = 9'b000001100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } life_state_t;

    // Single-step modulo wrap: idx is at most one position outside 0..size-1.
    function automatic int wrap_idx(input int idx, input int size);
        if (idx < 0) begin
            return idx + size;
        end else if (idx >= size) begin
            return idx - size;
        end else begin
            return idx;
        end
    endfunction

endpackage

// File: rtl/life_row_next.sv
// Combinational next-state for one row from the rows above, at and below it.
module life_row_next
    import life_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] row_above,
    input  logic [WIDTH-1:0] row_mid,
    input  logic [WIDTH-1:0] row_below,
    input  logic             above_valid,
    input  logic             below_valid,
    input  logic             wrap_mode,
    input  logic [8:0]       birth_mask,
    input  logic [8:0]       survive_mask,
    output logic [WIDTH-1:0] next_row
);

    logic [WIDTH-1:0] a_row;
    logic [WIDTH-1:0] b_row;

    assign a_row = above_valid ? row_above : '0;
    assign b_row = below_valid ? row_below : '0;

    for (genvar c = 0; c < WIDTH; c++) begin : g_col
        localparam int CL = wrap_idx(c - 1, WIDTH);
        localparam int CR = wrap_idx(c + 1, WIDTH);
        localparam bit HAS_L = (c > 0);
        localparam bit HAS_R = (c < WIDTH - 1);

        logic       l_ok;
        logic       r_ok;
        logic [7:0] nb;
        logic [3:0] cnt;

        // Wrapped columns are only real neighbours in toroidal mode.
        assign l_ok = wrap_mode | HAS_L;
        assign r_ok = wrap_mode | HAS_R;
        assign nb   = {a_row[CL] & l_ok, a_row[c], a_row[CR] & r_ok,
                       row_mid[CL] & l_ok, row_mid[CR] & r_ok,
                       b_row[CL] & l_ok, b_row[c], b_row[CR] & r_ok};
        assign cnt  = 4'($countones(nb));
        assign next_row[c] = row_mid[c] ? survive_mask[cnt] : birth_mask[cnt];
    end

endmodule

// File: rtl/life_row_engine.sv
// One Life generation per start, computed one row per clock from a captured snapshot.
// Optional population output enabled by defining LIFE_POPCOUNT_EN.
//
// state | meaning
// IDLE  | waiting for start; busy=0
// RUN   | computing row `row` into the result buffer, one row per cycle
// FIN   | board_output/gen_count just updated, done=1 for this cycle
module life_row_engine
    import life_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      wrap_mode,
    input  logic [8:0]                birth_mask,
    input  logic [8:0]                survive_mask,
    input  logic [WIDTH*HEIGHT-1:0]   board_input,
    output logic                      busy,
    output logic                      done,
    output logic [WIDTH*HEIGHT-1:0]   board_output,
    output logic [CNT_W-1:0]          gen_count
`ifdef LIFE_POPCOUNT_EN
    ,
    output logic [$clog2(WIDTH*HEIGHT+1)-1:0] population
`endif
);

    localparam int CELLS = WIDTH * HEIGHT;
    localparam int ROW_W = $clog2(HEIGHT);
    localparam int IDX_W = $clog2(CELLS);

    life_state_t        state;
    logic [ROW_W-1:0]   row;
    logic [CELLS-1:0]   snap_board;
    logic               snap_wrap;
    logic [8:0]         snap_birth;
    logic [8:0]         snap_survive;
    logic [CELLS-1:0]   result_buf;
    logic [CELLS-1:0]   result_next;
    logic [IDX_W-1:0]   above_base;
    logic [IDX_W-1:0]   mid_base;
    logic [IDX_W-1:0]   below_base;
    logic               first_row;
    logic               last_row;
    logic [WIDTH-1:0]   next_row;

`ifdef LIFE_POPCOUNT_EN
    localparam int POP_W = $clog2(CELLS + 1);
    logic [POP_W-1:0]   pop_acc;
`endif

    always_comb begin
        above_base  = IDX_W'(wrap_idx(int'(row) - 1, HEIGHT) * WIDTH);
        mid_base    = IDX_W'(int'(row) * WIDTH);
        below_base  = IDX_W'(wrap_idx(int'(row) + 1, HEIGHT) * WIDTH);
        first_row   = (row == '0);
        last_row    = (row == ROW_W'(HEIGHT - 1));
        result_next = result_buf;
        result_next[mid_base +: WIDTH] = next_row;
    end

    life_row_next #(
        .WIDTH(WIDTH)
    ) u_row_next (
        .row_above    (snap_board[above_base +: WIDTH]),
        .row_mid      (snap_board[mid_base +: WIDTH]),
        .row_below    (snap_board[below_base +: WIDTH]),
        .above_valid  (snap_wrap | ~first_row),
        .below_valid  (snap_wrap | ~last_row),
        .wrap_mode    (snap_wrap),
        .birth_mask   (snap_birth),
        .survive_mask (snap_survive),
        .next_row     (next_row)
    );

    // The final row is merged straight into board_output so done lines up with FIN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            row          <= '0;
            snap_board   <= '0;
            snap_wrap    <= 1'b0;
            snap_birth   <= '0;
            snap_survive <= '0;
            result_buf   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            board_output <= '0;
            gen_count    <= '0;
`ifdef LIFE_POPCOUNT_EN
            pop_acc      <= '0;
            population   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        snap_board   <= board_input;
                        snap_wrap    <= wrap_mode;
                        snap_birth   <= birth_mask;
                        snap_survive <= survive_mask;
                        row          <= '0;
                        busy         <= 1'b1;
                        state        <= RUN;
`ifdef LIFE_POPCOUNT_EN
                        pop_acc      <= '0;
`endif
                    end
                end
                RUN: begin
                    result_buf <= result_next;
                    row        <= row + 1'b1;
`ifdef LIFE_POPCOUNT_EN
                    pop_acc    <= pop_acc + POP_W'($countones(next_row));
`endif
                    if (last_row) begin
                        board_output <= result_next;
                        done         <= 1'b1;
                        gen_count    <= gen_count + 1'b1;
                        state        <= FIN;
`ifdef LIFE_POPCOUNT_EN
                        population   <= pop_acc + POP_W'($countones(next_row));
`endif
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_life_row_engine.sv
// Scoreboard bench for life_row_engine: directed boards with hand-derived next generations.
module tb_life_row_engine;

    localparam int W = 16;
    localparam int H = 16;
    localparam int N = W * H;
    localparam logic [8:0] B3   = 9'b000001000;
    localparam logic [8:0] B36  = 9'b001001000;
    localparam logic [8:0] S23  = 9'b000001100;

    logic           clk;
    logic           reset;
    logic           start;
    logic           wrap_mode;
    logic [8:0]     birth_mask;
    logic [8:0]     survive_mask;
    logic [N-1:0]   board_input;
    logic           busy;
    logic           done;
    logic [N-1:0]   board_output;
    logic [1:0]     gen_count;
`ifdef LIFE_POPCOUNT_EN
    logic [$clog2(N+1)-1:0] population;
`endif

    life_row_engine #(
        .WIDTH (W),
        .HEIGHT(H),
        .CNT_W (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .wrap_mode   (wrap_mode),
        .birth_mask  (birth_mask),
        .survive_mask(survive_mask),
        .board_input (board_input),
        .busy        (busy),
        .done        (done),
        .board_output(board_output),
        .gen_count   (gen_count)
`ifdef LIFE_POPCOUNT_EN
        ,
        .population  (population)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] board;
        logic [1:0]   gen;
        int           cyc;
        int           pop;
    } exp_t;

    exp_t       sb[$];
    exp_t       e_mon;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         done_seen = 0;
    int         last_start_cyc = 0;
    logic [1:0] exp_gen = 2'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] put(input logic [N-1:0] b, input int r, input int c);
        logic [N-1:0] t;
        t = b;
        t[r*W + c] = 1'b1;
        return t;
    endfunction

    function automatic logic [N-1:0] glider(input int ph, input int r0, input int c0);
        int rr[5];
        int cc[5];
        logic [N-1:0] b;
        case (ph)
            0:       begin rr = '{0, 1, 2, 2, 2}; cc = '{1, 2, 0, 1, 2}; end
            1:       begin rr = '{1, 1, 2, 2, 3}; cc = '{0, 2, 1, 2, 1}; end
            2:       begin rr = '{1, 2, 2, 3, 3}; cc = '{2, 0, 2, 1, 2}; end
            default: begin rr = '{1, 2, 2, 3, 3}; cc = '{1, 2, 3, 1, 2}; end
        endcase
        b = '0;
        for (int i = 0; i < 5; i++) b = put(b, (r0 + rr[i]) % H, (c0 + cc[i]) % W);
        return b;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_seen++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done cyc=%0d want no done", cyc);
            end else begin
                e_mon = sb.pop_front();
                chk("board_output", board_output, e_mon.board);
                chk("gen_count", N'(gen_count), N'(e_mon.gen));
                chk("done_latency_cycle", N'(cyc), N'(e_mon.cyc));
`ifdef LIFE_POPCOUNT_EN
                chk("population", N'(population), N'(e_mon.pop));
`endif
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout busy=%b want 0", busy);
        end
    endtask

    task automatic issue(input logic [N-1:0] bin, input logic w, input logic [8:0] bm,
                         input logic [8:0] sm, input logic [N-1:0] exp_b, input int exp_p);
        exp_t e;
        wait_idle();
        exp_gen = exp_gen + 2'd1;
        e.board = exp_b;
        e.gen   = exp_gen;
        e.cyc   = cyc + 17;
        e.pop   = exp_p;
        sb.push_back(e);
        last_start_cyc = cyc;
        board_input  = bin;
        wrap_mode    = w;
        birth_mask   = bm;
        survive_mask = sm;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout done=%b want 1", done);
        end
        @(negedge clk);
    endtask

    task automatic step(input logic [N-1:0] bin, input logic w, input logic [8:0] bm,
                        input logic [8:0] sm, input logic [N-1:0] exp_b, input int exp_p);
        issue(bin, w, bm, sm, exp_b, exp_p);
        wait_done();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_gen = 2'd0;
    endtask

    logic [N-1:0] blink0, blink1, hl_in, hl_b36, hl_b3, g_dead;
    int           seen0;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        wrap_mode = 1'b0;
        birth_mask = '0;
        survive_mask = '0;
        board_input = '0;

        blink0 = put(put(put('0, 5, 4), 5, 5), 5, 6);
        blink1 = put(put(put('0, 4, 5), 5, 5), 6, 5);
        hl_in = '0;
        for (int c = 7; c <= 9; c++) hl_in = put(put(hl_in, 7, c), 9, c);
        hl_b3  = put(put(put(put('0, 6, 8), 7, 8), 9, 8), 10, 8);
        hl_b36 = put(hl_b3, 8, 8);
        g_dead = put(put(put(put('0, 14, 13), 14, 15), 15, 14), 15, 15);

        repeat (3) @(negedge clk);
        chk("reset_busy", N'(busy), '0);
        chk("reset_done", N'(done), '0);
        chk("reset_board", board_output, '0);
        chk("reset_gen", N'(gen_count), '0);
        reset = 1'b0;
        @(negedge clk);

        // Blinker oscillation, dead edges, Conway rule.
        step(blink0, 1'b0, B3, S23, blink1, 3);
        step(blink1, 1'b0, B3, S23, blink0, 3);

        // Glider across the torus corner: four steps land it one cell down-right.
        step(glider(0, 13, 13), 1'b1, B3, S23, glider(1, 13, 13), 5);
        step(glider(1, 13, 13), 1'b1, B3, S23, glider(2, 13, 13), 5);
        step(glider(2, 13, 13), 1'b1, B3, S23, glider(3, 13, 13), 5);
        step(glider(3, 13, 13), 1'b1, B3, S23, glider(0, 14, 14), 5);

        // Same glider with dead edges: the birth below row 15 is lost.
        step(glider(0, 13, 13), 1'b0, B3, S23, g_dead, 4);

        // HighLife births the 6-neighbour centre; Conway does not.
        step(hl_in, 1'b0, B36, S23, hl_b36, 5);
        step(hl_in, 1'b0, B3, S23, hl_b3, 4);

        // Start pulses and input changes during RUN are ignored.
        seen0 = done_seen;
        issue(blink0, 1'b0, B3, S23, blink1, 3);
        while (cyc < last_start_cyc + 3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        board_input = '1;
        birth_mask = 9'h1ff;
        while (cyc < last_start_cyc + 10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (25) @(negedge clk);
        chk("single_done_count", N'(done_seen - seen0), N'(1));
        chk("no_queued_step_busy", N'(busy), '0);

        // Reset mid-RUN abandons the step without a done.
        issue(blink1, 1'b0, B3, S23, blink0, 3);
        while (cyc < last_start_cyc + 8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        exp_gen = 2'd0;
        seen0 = done_seen;
        chk("abort_busy", N'(busy), '0);
        chk("abort_done", N'(done), '0);
        chk("abort_board", board_output, '0);
        chk("abort_gen", N'(gen_count), '0);
        repeat (25) @(negedge clk);
        chk("abort_no_done", N'(done_seen - seen0), '0);
        step(blink0, 1'b0, B3, S23, blink1, 3);

        // Two-bit generation counter wraps 1,2,3,0,1.
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) step(blink0, 1'b0, B3, S23, blink1, 3);
            else            step(blink1, 1'b0, B3, S23, blink0, 3);
        end
        chk("gen_wrap_final", N'(gen_count), N'(1));
        chk("scoreboard_drained", N'(sb.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout cyc=%0d want finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
